// File: rtl/instruction_decode_pkg.sv
// Purpose: shared DLX definitions for the ID stage: widths, opcodes, control word layout, decoder.
// Ports:   none (package).
// Notes:   the control word layout is {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,alu_op[1:0]}.
package instruction_decode_pkg;

    localparam int DATA_W     = 32;
    localparam int PC_W       = 10;
    localparam int REG_ADDR_W = 5;
    localparam int INSTR_W    = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Branches and jumps are finished in ID, so they carry no work into EX.
    // The all-zero word is the canonical NOP even though its opcode is R-type.
    function automatic ctrl_t decode_ctrl(input logic [INSTR_W-1:0] instr);
        ctrl_t c;
        c = CTRL_NOP;
        if (instr != '0) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                    c.alu_op    = ALU_OP_RTYPE;
                end
                OP_ADDI: begin
                    c.reg_write = 1'b1;
                    c.alu_src   = 1'b1;
                    c.alu_op    = ALU_OP_ADD;
                end
                OP_LW: begin
                    c.reg_write  = 1'b1;
                    c.mem_read   = 1'b1;
                    c.mem_to_reg = 1'b1;
                    c.alu_src    = 1'b1;
                    c.alu_op     = ALU_OP_ADD;
                end
                OP_SW: begin
                    c.mem_write = 1'b1;
                    c.alu_src   = 1'b1;
                    c.alu_op    = ALU_OP_ADD;
                end
                default: c = CTRL_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Purpose: bundles the IF->ID inputs, WB/MEM feedback, redirect/stall outputs and the ID/EX latch.
// Ports:   master = ID stage (drives redirect/stall and idex_*), slave = surrounding pipeline.
// Notes:   clock and reset are plain ports on the modules, not part of this bundle.
interface instruction_decode_if;
    import instruction_decode_pkg::*;

    logic [INSTR_W-1:0]    instruc_reg;
    logic [PC_W-1:0]       PC_plus_1;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;

    logic                  PC_sel;
    logic [PC_W-1:0]       jump_address;
    logic                  pc_stall;

    ctrl_t                 idex_ctrl;
    logic [DATA_W-1:0]     idex_rs_data;
    logic [DATA_W-1:0]     idex_rt_data;
    logic [DATA_W-1:0]     idex_imm;
    logic [REG_ADDR_W-1:0] idex_rt;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic [PC_W-1:0]       idex_pc_plus_1;

    modport master (
        input  instruc_reg, PC_plus_1, wb_reg_write, wb_addr, wb_data,
               exmem_reg_write, exmem_rd,
        output PC_sel, jump_address, pc_stall,
               idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
               idex_rt, idex_rd, idex_pc_plus_1
    );

    modport slave (
        output instruc_reg, PC_plus_1, wb_reg_write, wb_addr, wb_data,
               exmem_reg_write, exmem_rd,
        input  PC_sel, jump_address, pc_stall,
               idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
               idex_rt, idex_rd, idex_pc_plus_1
    );

endinterface

// File: rtl/instruction_decode_register_file.sv
// Purpose: 32x32 register file, 2 async read ports, 1 write port, r0 hard-wired to zero.
// Ports:   clock/reset, rs/rt read address+data, WB write enable/address/data.
// Notes:   reads see a same-cycle WB write (write-through bypass); async reset clears all entries.
module instruction_decode_register_file
    import instruction_decode_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] regs [2**REG_ADDR_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wr_en && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = (wr_en && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Purpose: DLX ID stage: decode, register read, beq/bne/j resolution, hazard stalls, ID/EX latch.
// Ports:   clock, reset (async, active-high), id (master modport of instruction_decode_if).
// Notes:   PC_sel/jump_address/pc_stall are combinational from the current instruction (0 cycles);
//          idex_* is registered every cycle (1 cycle); a stall inserts a bubble and holds IF.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    instruction_decode_if.master  id
);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    ctrl_t                 dec_ctrl;
    logic                  is_beq;
    logic                  is_bne;
    logic                  is_j;
    logic                  squash_q;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  load_use;
    logic                  br_hazard;
    logic                  stall;
    logic                  taken;
    logic [PC_W-1:0]       br_target;
    logic [PC_W-1:0]       target;

    assign opcode   = id.instruc_reg[31:26];
    assign rs       = id.instruc_reg[25:21];
    assign rt       = id.instruc_reg[20:16];
    assign rd       = id.instruc_reg[15:11];
    assign imm_ext  = {{(DATA_W-16){id.instruc_reg[15]}}, id.instruc_reg[15:0]};
    assign dec_ctrl = decode_ctrl(id.instruc_reg);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);

    instruction_decode_register_file u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (id.wb_reg_write),
        .wr_addr (id.wb_addr),
        .wr_data (id.wb_data)
    );

    // Hazard unit and branch resolution. A squashed (wrong-path) instruction is
    // inert: it cannot stall and cannot redirect. A stall always wins over a
    // branch decision because the compare would use stale operands.
    always_comb begin
        ex_dest   = id.idex_ctrl.reg_dst ? id.idex_rd : id.idex_rt;
        load_use  = id.idex_ctrl.mem_read && (id.idex_rt != '0) &&
                    ((id.idex_rt == rs) || (id.idex_rt == rt));
        br_hazard = 1'b0;
        if (is_beq || is_bne) begin
            if (id.idex_ctrl.reg_write && (ex_dest != '0) &&
                ((ex_dest == rs) || (ex_dest == rt))) begin
                br_hazard = 1'b1;
            end
            if (id.exmem_reg_write && (id.exmem_rd != '0) &&
                ((id.exmem_rd == rs) || (id.exmem_rd == rt))) begin
                br_hazard = 1'b1;
            end
        end
        stall     = !squash_q && (load_use || br_hazard);
        br_target = id.PC_plus_1 + imm_ext[PC_W-1:0];
        target    = is_j ? id.instruc_reg[PC_W-1:0] : br_target;
        taken     = !squash_q && !stall &&
                    ((is_beq && (rs_data == rt_data)) ||
                     (is_bne && (rs_data != rt_data)) ||
                     is_j);
    end

    assign id.PC_sel       = !taken;
    assign id.jump_address = taken ? target : '0;
    assign id.pc_stall     = stall;

    // The instruction fetched right after a taken redirect is on the wrong path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            squash_q <= 1'b0;
        end else begin
            squash_q <= taken;
        end
    end

    // ID/EX latch: a bubble only clears ctrl; the data fields carry along.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id.idex_ctrl      <= CTRL_NOP;
            id.idex_rs_data   <= '0;
            id.idex_rt_data   <= '0;
            id.idex_imm       <= '0;
            id.idex_rt        <= '0;
            id.idex_rd        <= '0;
            id.idex_pc_plus_1 <= '0;
        end else begin
            id.idex_ctrl      <= (squash_q || stall) ? CTRL_NOP : dec_ctrl;
            id.idex_rs_data   <= rs_data;
            id.idex_rt_data   <= rt_data;
            id.idex_imm       <= imm_ext;
            id.idex_rt        <= rt;
            id.idex_rd        <= rd;
            id.idex_pc_plus_1 <= id.PC_plus_1;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Purpose: directed scoreboard bench for instruction_decode.
// Ports:   none; drives an instruction_decode_if instance and the clock/reset.
// Notes:   the driver pushes one expectation per cycle; the monitor checks redirect/stall on the
//          falling edge and the ID/EX latch just after the following rising edge.
module tb_instruction_decode;
    import instruction_decode_pkg::*;

    typedef struct {
        logic        pc_sel;
        logic [9:0]  ja;
        logic        stall;
        logic [7:0]  ctrl;
        logic        chk_data;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [9:0]  pc1;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb [$];
    exp_t mon_e;

    instruction_decode_if bus ();

    instruction_decode dut (
        .clock (clock),
        .reset (reset),
        .id    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t e_ctl(input logic ps, input logic [9:0] ja, input logic st,
                                   input logic [7:0] c);
        exp_t e;
        e = '{pc_sel: ps, ja: ja, stall: st, ctrl: c, chk_data: 1'b0,
              rs_d: '0, rt_d: '0, imm: '0, rt: '0, rd: '0, pc1: '0};
        return e;
    endfunction

    function automatic exp_t e_dat(input logic ps, input logic [9:0] ja, input logic st,
                                   input logic [7:0] c, input logic [31:0] rs_d,
                                   input logic [31:0] rt_d, input logic [31:0] imm,
                                   input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [9:0] pc1);
        exp_t e;
        e = '{pc_sel: ps, ja: ja, stall: st, ctrl: c, chk_data: 1'b1,
              rs_d: rs_d, rt_d: rt_d, imm: imm, rt: rt, rd: rd, pc1: pc1};
        return e;
    endfunction

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Called at posedge+2: drive one ID cycle, queue its expectation, advance one clock.
    task automatic step(input logic [31:0] instr, input logic [9:0] pc1,
                        input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic exw, input logic [4:0] exrd, input exp_t e);
        bus.instruc_reg     = instr;
        bus.PC_plus_1       = pc1;
        bus.wb_reg_write    = wbw;
        bus.wb_addr         = wba;
        bus.wb_data         = wbd;
        bus.exmem_reg_write = exw;
        bus.exmem_rd        = exrd;
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pc_sel", {31'd0, bus.PC_sel}, {31'd0, mon_e.pc_sel});
                chk("jump_address", {22'd0, bus.jump_address}, {22'd0, mon_e.ja});
                chk("pc_stall", {31'd0, bus.pc_stall}, {31'd0, mon_e.stall});
                @(posedge clock);
                #1;
                chk("idex_ctrl", {24'd0, bus.idex_ctrl}, {24'd0, mon_e.ctrl});
                if (mon_e.chk_data) begin
                    chk("idex_rs_data", bus.idex_rs_data, mon_e.rs_d);
                    chk("idex_rt_data", bus.idex_rt_data, mon_e.rt_d);
                    chk("idex_imm", bus.idex_imm, mon_e.imm);
                    chk("idex_rt", {27'd0, bus.idex_rt}, {27'd0, mon_e.rt});
                    chk("idex_rd", {27'd0, bus.idex_rd}, {27'd0, mon_e.rd});
                    chk("idex_pc_plus_1", {22'd0, bus.idex_pc_plus_1}, {22'd0, mon_e.pc1});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // Driver
    initial begin
        logic [31:0] beq_fwd;
        logic [31:0] bne_r7;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.instruc_reg     = '0;
        bus.PC_plus_1       = '0;
        bus.wb_reg_write    = 1'b0;
        bus.wb_addr         = '0;
        bus.wb_data         = '0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = '0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_idex_ctrl", {24'd0, bus.idex_ctrl}, 32'h0);
        chk("rst_idex_rs_data", bus.idex_rs_data, 32'h0);
        chk("rst_idex_imm", bus.idex_imm, 32'h0);
        chk("rst_idex_pc_plus_1", {22'd0, bus.idex_pc_plus_1}, 32'h0);
        chk("rst_pc_sel", {31'd0, bus.PC_sel}, 32'h1);
        chk("rst_pc_stall", {31'd0, bus.pc_stall}, 32'h0);
        reset = 1'b0;

        beq_fwd = i_type(OP_BEQ, 5'd1, 5'd2, 16'd3);
        bne_r7  = i_type(OP_BNE, 5'd7, 5'd0, 16'd2);

        // WB bypass: r5 written and read in the same cycle
        step(r_add(5'd1, 5'd5, 5'd0), 10'd1, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h86, 32'hAA, 32'h0, 32'h0820, 5'd0, 5'd1, 10'd1));
        step(32'h0, 10'd2, 1'b1, 5'd1, 32'h55, 1'b0, 5'd0, e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        step(i_type(OP_ADDI, 5'd5, 5'd6, 16'hFFFF), 10'd3, 1'b1, 5'd2, 32'h55, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h88, 32'hAA, 32'h0, 32'hFFFF_FFFF, 5'd6, 5'd31, 10'd3));
        // beq taken, then a taken-looking wrong-path beq that must be squashed
        step(beq_fwd, 10'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_dat(1'b0, 10'd13, 1'b0, 8'h00, 32'h55, 32'h55, 32'h3, 5'd2, 5'd0, 10'd10));
        step(i_type(OP_BEQ, 5'd1, 5'd2, 16'd5), 10'd11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        // j right after the squash slot: flag must already be clear
        step({OP_J, 26'h3FF}, 10'd13, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b0, 10'h3FF, 1'b0, 8'h00));
        step(r_add(5'd9, 5'd1, 5'd2), 10'd14, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        // bne with equal operands is not taken
        step(i_type(OP_BNE, 5'd1, 5'd2, 16'd3), 10'd20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        // backward branch wraps: 5 + (-20) mod 1024 = 1009
        step(i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFEC), 10'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_dat(1'b0, 10'd1009, 1'b0, 8'h00, 32'h55, 32'h55, 32'hFFFF_FFEC, 5'd2, 5'd31, 10'd5));
        step(32'h0, 10'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        // load-use: one stall cycle with bubble, then the add proceeds
        step(i_type(OP_LW, 5'd0, 5'd3, 16'd0), 10'd30, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b1, 10'd0, 1'b0, 8'hD8));
        step(r_add(5'd4, 5'd3, 5'd3), 10'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_ctl(1'b1, 10'd0, 1'b1, 8'h00));
        step(r_add(5'd4, 5'd3, 5'd3), 10'd31, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h86, 32'h33, 32'h33, 32'h2020, 5'd3, 5'd4, 10'd31));
        // branch operand produced by add r7: stall while in EX, then in MEM, then resolve
        step(r_add(5'd7, 5'd1, 5'd2), 10'd40, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h86, 32'h55, 32'h55, 32'h3820, 5'd2, 5'd7, 10'd40));
        step(bne_r7, 10'd41, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e_ctl(1'b1, 10'd0, 1'b1, 8'h00));
        step(bne_r7, 10'd41, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, e_ctl(1'b1, 10'd0, 1'b1, 8'h00));
        step(bne_r7, 10'd41, 1'b1, 5'd7, 32'hAA, 1'b0, 5'd0,
             e_dat(1'b0, 10'd43, 1'b0, 8'h00, 32'hAA, 32'h0, 32'h2, 5'd0, 5'd0, 10'd41));
        step(32'h0, 10'd42, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, e_ctl(1'b1, 10'd0, 1'b0, 8'h00));
        step(i_type(OP_LW, 5'd0, 5'd3, 16'd0), 10'd50, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'hD8, 32'h0, 32'h33, 32'h0, 5'd3, 5'd0, 10'd50));

        // Reset asserted while a load-use stall is active
        bus.instruc_reg = r_add(5'd4, 5'd3, 5'd3);
        bus.PC_plus_1   = 10'd51;
        #2;
        chk("pre_rst_pc_stall", {31'd0, bus.pc_stall}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_idex_ctrl", {24'd0, bus.idex_ctrl}, 32'h0);
        chk("mid_rst_pc_stall", {31'd0, bus.pc_stall}, 32'h0);
        chk("mid_rst_pc_sel", {31'd0, bus.PC_sel}, 32'h1);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #2;

        // Registers cleared by reset; r0 ignores writes and its bypass
        step(r_add(5'd4, 5'd0, 5'd3), 10'd51, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h86, 32'h0, 32'h0, 32'h2020, 5'd3, 5'd4, 10'd51));
        step(r_add(5'd1, 5'd0, 5'd0), 10'd52, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
             e_dat(1'b1, 10'd0, 1'b0, 8'h86, 32'h0, 32'h0, 32'h0820, 5'd0, 5'd1, 10'd52));

        repeat (2) @(posedge clock);
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
